// File: rtl/lab_event_readout_pkg.sv
// Shared constants and FSM state type for the LAB event readout block.
package lab_event_readout_pkg;

  localparam int unsigned LabW  = 2;
  localparam int unsigned WordW = 11;
  localparam int unsigned AddrW = LabW + WordW;

  localparam logic [7:0] HdrTag = 8'hEC;
  localparam logic [7:0] TrlTag = 8'hE5;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StSelect,
    StSettle,
    StWaitDone,
    StRead,
    StDrain,
    StNext,
    StTrail
  } state_e;

endpackage

// File: rtl/lab_event_readout_if.sv
// Valid/ready word stream carrying event words to the readout bus/FIFO.
interface lab_event_readout_if;
  logic [31:0] dat;
  logic        valid;
  logic        ready;
  logic        last;

  modport master (output dat, output valid, output last, input ready);
  modport slave  (input dat, input valid, input last, output ready);
endinterface

// File: rtl/lab_readout_fifo.sv
// First-word-fall-through FIFO with occupancy count; storage is not reset.
module lab_readout_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 33,
  parameter int unsigned CntW  = $clog2(Depth + 1),
  parameter int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CntW'(Depth));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/lab_event_readout.sv
// Walks each enabled LAB's sample RAM after its done flag and streams
// header, samples and trailer with credit-based flow control over read latency.
module lab_event_readout
  import lab_event_readout_pkg::*;
#(
  parameter int unsigned NLab          = 4,
  parameter int unsigned WordsPerLab   = 1536,
  parameter int unsigned RdLatency     = 1,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [NLab-1:0]     lab_mask_i,
  input  logic                lab_done_i,
  output logic [AddrW-1:0]    lab_addr_o,
  input  logic [31:0]         lab_dat_i,
  lab_event_readout_if.master out_io,
  output logic                busy_o,
  output logic [NLab-1:0]     timeout_o
);

  localparam int unsigned FifoCntW = $clog2(FifoDepth + 1);
  localparam int unsigned TcntW    = $clog2(TimeoutCycles + 1);

  state_e             state_q, state_d;
  logic [NLab-1:0]    mask_q, mask_d, proc_q, proc_d, tmo_q, tmo_d;
  logic [LabW-1:0]    lab_q, lab_d, sel_lab;
  logic [WordW-1:0]   word_q, word_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [15:0]        evnum_q, evnum_d;
  logic               trl_sent_q, trl_sent_d;
  logic [RdLatency-1:0] tag_q, tag_d;

  logic               sel_found, issue, credit_ok, fifo_free;
  logic               ctl_push, fifo_push, fifo_empty, fifo_pop;
  logic [32:0]        ctl_wdata, fifo_wdata, fifo_rdata;
  logic [FifoCntW-1:0] fifo_cnt;
  logic [NLab-1:0]    pending;

  assign pending = mask_q & ~proc_q;

  // Downward scan so the final hit is the lowest pending lab.
  always_comb begin
    sel_found = 1'b0;
    sel_lab   = '0;
    for (int i = int'(NLab) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_lab   = LabW'(i);
      end
    end
  end

  // Words buffered plus words still in the RAM pipeline must fit the FIFO.
  assign credit_ok = (32'(fifo_cnt) + 32'($countones(tag_q))) < FifoDepth;
  assign fifo_free = fifo_cnt < FifoCntW'(FifoDepth);
  assign fifo_pop  = !fifo_empty && out_io.ready;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    proc_d     = proc_q;
    tmo_d      = tmo_q;
    lab_d      = lab_q;
    word_d     = word_q;
    tcnt_d     = tcnt_q;
    evnum_d    = evnum_q;
    trl_sent_d = trl_sent_q;
    issue      = 1'b0;
    ctl_push   = 1'b0;
    ctl_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d  = lab_mask_i;
          proc_d  = '0;
          tmo_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (fifo_free) begin
          ctl_push  = 1'b1;
          ctl_wdata = {1'b0, HdrTag, 4'h0, 4'(mask_q), evnum_q};
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (sel_found) begin
          lab_d   = sel_lab;
          word_d  = '0;
          state_d = StSettle;
        end else begin
          trl_sent_d = 1'b0;
          state_d    = StTrail;
        end
      end
      StSettle: begin
        tcnt_d  = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (lab_done_i) begin
          state_d = StRead;
        end else if (tcnt_q == TcntW'(TimeoutCycles)) begin
          tmo_d[lab_q] = 1'b1;
          state_d      = StNext;
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end
      StRead: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (word_q == WordW'(WordsPerLab - 1)) state_d = StDrain;
          else                                   word_d  = word_q + WordW'(1);
        end
      end
      StDrain: begin
        if (tag_q == '0) state_d = StNext;
      end
      StNext: begin
        proc_d[lab_q] = 1'b1;
        state_d       = StSelect;
      end
      StTrail: begin
        if (!trl_sent_q && fifo_free) begin
          ctl_push   = 1'b1;
          ctl_wdata  = {1'b1, TrlTag, 20'h0, 4'(tmo_q)};
          trl_sent_d = 1'b1;
        end
        if (fifo_pop && fifo_rdata[32]) begin
          evnum_d = evnum_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    tag_d = RdLatency'({tag_q, issue});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      proc_q     <= '0;
      tmo_q      <= '0;
      lab_q      <= '0;
      word_q     <= '0;
      tcnt_q     <= '0;
      evnum_q    <= '0;
      trl_sent_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      proc_q     <= proc_d;
      tmo_q      <= tmo_d;
      lab_q      <= lab_d;
      word_q     <= word_d;
      tcnt_q     <= tcnt_d;
      evnum_q    <= evnum_d;
      trl_sent_q <= trl_sent_d;
      tag_q      <= tag_d;
    end
  end

  // RAM returns never collide with header/trailer pushes: those occur with nothing in flight.
  assign fifo_push  = ctl_push || tag_q[RdLatency-1];
  assign fifo_wdata = tag_q[RdLatency-1] ? {1'b0, lab_dat_i} : ctl_wdata;

  lab_readout_fifo #(
    .Depth (FifoDepth),
    .Width (33)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_io.dat   = fifo_rdata[31:0];
  assign out_io.valid = !fifo_empty;
  assign out_io.last  = fifo_rdata[32] && !fifo_empty;
  assign lab_addr_o   = {lab_q, word_q};
  assign busy_o       = (state_q != StIdle);
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_lab_event_readout.sv
// Directed bench: expected event streams built from the readout rules, checked every transfer.
module tb_lab_event_readout;

  localparam int unsigned Words = 1536;
  localparam int unsigned Depth = 4;

  logic        clk, rst, start, lab_done;
  logic [3:0]  lab_mask, lab_done_vec, timeout;
  logic [12:0] lab_addr;
  logic [31:0] lab_dat;
  logic        busy;

  int          ram_mode;
  bit          rand_ready, chk_credit;

  int          n_chk, n_pass;
  logic [32:0] exp_q[$];
  logic [15:0] ev_model;

  int          ev_xfer, last_ev_xfer, adv, dpop;
  logic [31:0] hdr_word, first_data, trl_word;
  logic [12:0] prev_addr;
  logic [32:0] exp_w;

  lab_event_readout_if out_if();

  lab_event_readout #(
    .TimeoutCycles (100)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .lab_mask_i (lab_mask),
    .lab_done_i (lab_done),
    .lab_addr_o (lab_addr),
    .lab_dat_i  (lab_dat),
    .out_io     (out_if),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign lab_done = lab_done_vec[lab_addr[12:11]];

  function automatic logic [31:0] ram_word(input int mode, input int lab, input int w);
    logic [1:0]  l;
    logic [10:0] a;
    l = 2'(lab);
    a = 11'(w);
    case (mode)
      0:       return {21'h0, a};
      1:       return {14'h0, l, 5'h0, a};
      default: return 32'hC0DE0000 | {19'h0, l, a};
    endcase
  endfunction

  // One-cycle-latency RAM: address seen during a cycle appears as data in the next.
  initial begin
    logic [12:0] a;
    lab_dat = '0;
    forever begin
      @(negedge clk);
      a = lab_addr;
      @(posedge clk);
      #1 lab_dat = ram_word(ram_mode, int'(a[12:11]), int'(a[10:0]));
    end
  end

  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_if.ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ev_xfer = 0;
      adv     = 0;
    end else begin
      if (!busy) begin
        ev_xfer = 0;
        adv     = 0;
      end else if (lab_addr[12:11] == prev_addr[12:11] &&
                   lab_addr[10:0] == prev_addr[10:0] + 11'd1) begin
        adv++;
      end
      if (out_if.valid && out_if.ready) begin
        if (ev_xfer == 0) hdr_word = out_if.dat;
        if (ev_xfer == 1) first_data = out_if.dat;
        ev_xfer++;
        if (out_if.last) begin
          trl_word     = out_if.dat;
          last_ev_xfer = ev_xfer;
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL stream_extra: got 0x%0h, expected no word", {out_if.last, out_if.dat});
        end else begin
          exp_w = exp_q.pop_front();
          chk("stream_word", 64'({out_if.last, out_if.dat}), 64'(exp_w));
        end
      end
      if (chk_credit && busy) begin
        dpop = (ev_xfer > 0) ? ev_xfer - 1 : 0;
        n_chk++;
        if (adv - dpop > int'(Depth))
          $display("FAIL credit_bound: outstanding %0d, limit %0d", adv - dpop, Depth);
        else n_pass++;
      end
    end
    prev_addr = lab_addr;
  end

  task automatic build_expect(input logic [3:0] mask, input logic [3:0] done_v, input int mode,
                              output logic [3:0] tmo, output int n_words);
    tmo     = 4'h0;
    n_words = 2;
    exp_q.push_back({1'b0, 8'hEC, 4'h0, mask, ev_model});
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        if (done_v[l]) begin
          for (int w = 0; w < int'(Words); w++) exp_q.push_back({1'b0, ram_word(mode, l, w)});
          n_words += Words;
        end else begin
          tmo[l] = 1'b1;
        end
      end
    end
    exp_q.push_back({1'b1, 8'hE5, 20'h0, tmo});
  endtask

  task automatic run_event(input logic [3:0] mask, input logic [3:0] done_v, input int mode,
                           input bit rnd, input bit poke);
    logic [3:0] tmo;
    int         n_words;
    int         cyc;
    ram_mode     = mode;
    lab_done_vec = done_v;
    rand_ready   = rnd;
    chk_credit   = rnd;
    build_expect(mask, done_v, mode, tmo, n_words);
    @(posedge clk);
    #1 start = 1'b1;
    lab_mask = mask;
    @(posedge clk);
    #1 start = 1'b0;
    lab_mask = 4'hF;
    chk("busy_after_start", 64'(busy), 64'(1));
    if (poke) begin
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 40000);
    chk("event_done", 64'(busy), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("timeout_o", 64'(timeout), 64'(tmo));
    chk("transfer_count", 64'(last_ev_xfer), 64'(n_words));
    exp_q.delete();
    rand_ready = 1'b0;
    chk_credit = 1'b0;
    ev_model++;
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    lab_mask     = 4'h0;
    lab_done_vec = 4'h0;
    ram_mode     = 0;
    rand_ready   = 1'b0;
    chk_credit   = 1'b0;
    ev_model     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 64'(lab_addr), 64'(0));
    chk("rst_valid", 64'(out_if.valid), 64'(0));
    chk("rst_last", 64'(out_if.last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    run_event(4'b0001, 4'b1111, 0, 1'b0, 1'b0);
    chk("t1_header", 64'(hdr_word), 64'(32'hEC010000));
    chk("t1_first_word", 64'(first_data), 64'(32'h0));
    chk("t1_trailer", 64'(trl_word), 64'(32'hE5000000));
    chk("t1_total", 64'(last_ev_xfer), 64'(1538));

    run_event(4'b1010, 4'b1111, 1, 1'b0, 1'b0);
    chk("t2_header", 64'(hdr_word), 64'(32'hEC0A0001));
    chk("t2_first_word", 64'(first_data), 64'(32'h00010000));

    run_event(4'b0100, 4'b1111, 2, 1'b1, 1'b0);
    chk("t3_first_word", 64'(first_data), 64'(32'hC0DE1000));

    run_event(4'b0011, 4'b0010, 1, 1'b0, 1'b0);
    chk("t4_first_word", 64'(first_data), 64'(32'h00010000));
    chk("t4_trailer", 64'(trl_word), 64'(32'hE5000001));
    chk("t4_timeout", 64'(timeout), 64'(4'b0001));

    // Abort an event mid-read with an asynchronous reset.
    begin
      logic [3:0] tmo;
      int         n_words;
      ram_mode     = 0;
      lab_done_vec = 4'b1111;
      build_expect(4'b0001, 4'b1111, 0, tmo, n_words);
      @(posedge clk);
      #1 start = 1'b1;
      lab_mask = 4'b0001;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("busy_before_rst", 64'(busy), 64'(1));
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(out_if.valid), 64'(0));
      chk("async_rst_busy", 64'(busy), 64'(0));
      chk("async_rst_addr", 64'(lab_addr), 64'(0));
      exp_q.delete();
      ev_model = 16'h0;
      @(negedge clk) rst = 1'b0;
    end

    for (int k = 0; k < 3; k++) begin
      run_event(4'b0000, 4'b0000, 0, 1'b0, 1'b1);
      chk("mask0_header", 64'(hdr_word), 64'(32'hEC000000 + k));
      chk("mask0_trailer", 64'(trl_word), 64'(32'hE5000000));
    end

    repeat (5) @(posedge clk);
    #1 chk("final_idle", 64'(busy), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
